// File: rtl/rob_multi_cdb_if.sv
// Dispatch, CDB, commit and lookup bus of the multi-CDB reorder buffer.
// The driving side (dispatch/execution/register file) uses master; the ROB uses slave.
interface rob_multi_cdb_if #(
   parameter int ROB_WIDTH  = 4,
   parameter int REG_WIDTH  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int N_CDB      = 2
);
   logic                        flush;
   logic                        alloc_req;
   logic [REG_WIDTH-1:0]        alloc_arch_num;
   logic                        alloc_ready;
   logic [ROB_WIDTH-1:0]        alloc_tag;
   logic [N_CDB-1:0]            cdb_valid;
   logic [N_CDB*ROB_WIDTH-1:0]  cdb_tag;
   logic [N_CDB*DATA_WIDTH-1:0] cdb_data;
   logic                        commit_valid;
   logic                        commit_ready;
   logic [ROB_WIDTH-1:0]        commit_tag;
   logic [REG_WIDTH-1:0]        commit_arch_num;
   logic [DATA_WIDTH-1:0]       commit_data;
   logic [ROB_WIDTH-1:0]        rd_tag;
   logic                        rd_valid;
   logic [DATA_WIDTH-1:0]       rd_data;
   logic [ROB_WIDTH:0]          count;

   modport master (
      output flush, alloc_req, alloc_arch_num, cdb_valid, cdb_tag, cdb_data,
             commit_ready, rd_tag,
      input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_arch_num,
             commit_data, rd_valid, rd_data, count
   );

   modport slave (
      input  flush, alloc_req, alloc_arch_num, cdb_valid, cdb_tag, cdb_data,
             commit_ready, rd_tag,
      output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_arch_num,
             commit_data, rd_valid, rd_data, count
   );
endinterface

// File: rtl/rob_multi_cdb.sv
// Reorder buffer: circular queue allocating one tag per cycle, accepting N_CDB result
// broadcasts per cycle, retiring in order, with a CDB-bypassing operand lookup.
module rob_multi_cdb #(
   parameter int ROB_WIDTH  = 4,
   parameter int REG_WIDTH  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int N_CDB      = 2
) (
   input  logic             clk,
   input  logic             rstn,
   rob_multi_cdb_if.slave   rob
);
   localparam int                 DEPTH   = 2**ROB_WIDTH;
   localparam logic [ROB_WIDTH:0] DEPTH_C = (ROB_WIDTH+1)'(DEPTH);

   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [REG_WIDTH-1:0]  arch_q [DEPTH];
   logic [REG_WIDTH-1:0]  arch_d [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_d [DEPTH];
   logic [ROB_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
   logic [ROB_WIDTH:0]    count_q, count_d;
   logic [ROB_WIDTH-1:0]  cdb_tag_w;
   logic                  alloc_fire, commit_fire;

   // Offset from head, computed modulo DEPTH by the natural tag-width wrap.
   function automatic logic occupied(input logic [ROB_WIDTH-1:0] t,
                                     input logic [ROB_WIDTH-1:0] hd,
                                     input logic [ROB_WIDTH:0]   cnt);
      logic [ROB_WIDTH-1:0] off;
      off = t - hd;
      return {1'b0, off} < cnt;
   endfunction

   assign rob.alloc_ready     = (count_q != DEPTH_C);
   assign rob.alloc_tag       = tail_q;
   assign rob.commit_valid    = (count_q != '0) && valid_q[head_q] && !rob.flush;
   assign rob.commit_tag      = head_q;
   assign rob.commit_arch_num = arch_q[head_q];
   assign rob.commit_data     = data_q[head_q];
   assign rob.count           = count_q;

   assign alloc_fire  = rob.alloc_req && rob.alloc_ready;
   assign commit_fire = rob.commit_valid && rob.commit_ready;

   always_comb begin
      rob.rd_valid = valid_q[rob.rd_tag];
      rob.rd_data  = data_q[rob.rd_tag];
      for (int i = 0; i < N_CDB; i++) begin
         if (rob.cdb_valid[i] && rob.cdb_tag[i*ROB_WIDTH +: ROB_WIDTH] == rob.rd_tag) begin
            rob.rd_valid = 1'b1;
            rob.rd_data  = rob.cdb_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      valid_d   = valid_q;
      arch_d    = arch_q;
      data_d    = data_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      cdb_tag_w = '0;
      if (rob.flush) begin
         valid_d = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc_fire) begin
            valid_d[tail_q] = 1'b0;
            arch_d[tail_q]  = rob.alloc_arch_num;
            tail_d          = tail_q + 1'b1;
         end
         // Later ports overwrite earlier ones, so the highest index wins a tag clash.
         for (int i = 0; i < N_CDB; i++) begin
            cdb_tag_w = rob.cdb_tag[i*ROB_WIDTH +: ROB_WIDTH];
            if (rob.cdb_valid[i] && occupied(cdb_tag_w, head_q, count_q)) begin
               valid_d[cdb_tag_w] = 1'b1;
               data_d[cdb_tag_w]  = rob.cdb_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
         end
         case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      arch_q <= arch_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_rob_multi_cdb.sv
// Scoreboard bench for rob_multi_cdb: allocations push expected commits, commits pop and compare.
module tb_rob_multi_cdb;
   logic clk;
   logic rstn;
   int   total;
   int   bad;

   typedef struct packed {
      logic [3:0] tag;
      logic [4:0] arch;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mdl_data [16];
   logic [3:0]  mdl_tail;

   rob_multi_cdb_if #(.ROB_WIDTH(4), .REG_WIDTH(5), .DATA_WIDTH(32), .N_CDB(2)) bus ();

   rob_multi_cdb #(.ROB_WIDTH(4), .REG_WIDTH(5), .DATA_WIDTH(32), .N_CDB(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .rob  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.cdb_valid == 2'b11 && bus.cdb_tag[3:0] == bus.cdb_tag[7:4])
         $error("illegal duplicate CDB tag %0d", bus.cdb_tag[3:0]);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.flush          = 1'b0;
      bus.alloc_req      = 1'b0;
      bus.alloc_arch_num = '0;
      bus.cdb_valid      = '0;
      bus.cdb_tag        = '0;
      bus.cdb_data       = '0;
      bus.commit_ready   = 1'b0;
      bus.rd_tag         = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rstn = 1'b0;
      #4;
      rstn = 1'b1;
      sbq.delete();
      mdl_tail = '0;
      tick();
   endtask

   task automatic alloc(input logic [4:0] arch);
      bus.alloc_req      = 1'b1;
      bus.alloc_arch_num = arch;
      sbq.push_back('{tag: mdl_tail, arch: arch});
      mdl_tail = mdl_tail + 1'b1;
   endtask

   task automatic cdb(input int port, input logic [3:0] tag, input logic [31:0] data);
      bus.cdb_valid[port]         = 1'b1;
      bus.cdb_tag[port*4 +: 4]    = tag;
      bus.cdb_data[port*32 +: 32] = data;
      mdl_data[tag]               = data;
   endtask

   task automatic test_reset;
      do_reset();
      total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_alloc_ready got=%b want=1", bus.alloc_ready); end
      total++; if (bus.alloc_tag !== 4'd0) begin bad++; $display("FAIL rst_alloc_tag got=%0d want=0", bus.alloc_tag); end
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.count); end
      total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL rst_commit_valid got=%b want=0", bus.commit_valid); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b want=0", bus.rd_valid); end
   endtask

   task automatic test_fill;
      int   budget;
      exp_t f;
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         alloc(5'(i));
         tick();
      end
      bus.alloc_req = 1'b0;
      total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d want=16", bus.count); end
      total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", bus.alloc_ready); end
      bus.alloc_req = 1'b1;
      bus.alloc_arch_num = 5'd17;
      tick();
      bus.alloc_req = 1'b0;
      total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fill_17th_count got=%0d want=16", bus.count); end
      total++; if (bus.alloc_tag !== 4'd0) begin bad++; $display("FAIL fill_tail_wrap got=%0d want=0", bus.alloc_tag); end
      for (int t = 0; t < 16; t += 2) begin
         cdb(0, 4'(t), 32'h100 + t);
         cdb(1, 4'(t + 1), 32'h200 + t);
         tick();
      end
      bus.cdb_valid = '0;
      bus.commit_ready = 1'b1;
      budget = 0;
      while (sbq.size() != 0 && budget < 64) begin
         if (bus.commit_valid === 1'b1) begin
            f = sbq.pop_front();
            total++; if (bus.commit_tag !== f.tag) begin bad++; $display("FAIL fill_commit_tag got=%0d want=%0d", bus.commit_tag, f.tag); end
            total++; if (bus.commit_arch_num !== f.arch) begin bad++; $display("FAIL fill_commit_arch got=%0d want=%0d", bus.commit_arch_num, f.arch); end
            total++; if (bus.commit_data !== mdl_data[f.tag]) begin bad++; $display("FAIL fill_commit_data got=%h want=%h", bus.commit_data, mdl_data[f.tag]); end
         end
         tick();
         budget++;
      end
      total++; if (sbq.size() != 0) begin bad++; $display("FAIL fill_drain_timeout left=%0d want=0", sbq.size()); end
      bus.commit_ready = 1'b0;
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL fill_drained_count got=%0d want=0", bus.count); end
   endtask

   task automatic test_out_of_order;
      int   budget;
      exp_t f;
      do_reset();
      alloc(5'd3); tick();
      alloc(5'd4); tick();
      alloc(5'd5); tick();
      bus.alloc_req = 1'b0;
      bus.commit_ready = 1'b1;
      cdb(0, 4'd2, 32'hC);
      cdb(1, 4'd0, 32'hA);
      total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_cycle_k_valid got=%b want=0", bus.commit_valid); end
      tick();
      bus.cdb_valid = '0;
      cdb(0, 4'd1, 32'hB);
      total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL ooo_k1_valid got=%b want=1", bus.commit_valid); end
      f = sbq.pop_front();
      total++; if (bus.commit_tag !== f.tag) begin bad++; $display("FAIL ooo_k1_tag got=%0d want=%0d", bus.commit_tag, f.tag); end
      total++; if (bus.commit_data !== 32'hA) begin bad++; $display("FAIL ooo_k1_data got=%h want=a", bus.commit_data); end
      tick();
      bus.cdb_valid = '0;
      budget = 0;
      while (sbq.size() != 0 && budget < 16) begin
         if (bus.commit_valid === 1'b1) begin
            f = sbq.pop_front();
            total++; if (bus.commit_tag !== f.tag) begin bad++; $display("FAIL ooo_tag got=%0d want=%0d", bus.commit_tag, f.tag); end
            total++; if (bus.commit_arch_num !== f.arch) begin bad++; $display("FAIL ooo_arch got=%0d want=%0d", bus.commit_arch_num, f.arch); end
            total++; if (bus.commit_data !== mdl_data[f.tag]) begin bad++; $display("FAIL ooo_data got=%h want=%h", bus.commit_data, mdl_data[f.tag]); end
         end
         tick();
         budget++;
      end
      total++; if (sbq.size() != 0) begin bad++; $display("FAIL ooo_drain_timeout left=%0d want=0", sbq.size()); end
      bus.commit_ready = 1'b0;
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL ooo_count got=%0d want=0", bus.count); end
   endtask

   task automatic test_full_commit_alloc;
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         alloc(5'(i));
         tick();
      end
      bus.alloc_req = 1'b0;
      cdb(0, 4'd0, 32'h55);
      tick();
      bus.cdb_valid = '0;
      bus.commit_ready = 1'b1;
      bus.alloc_req = 1'b1;
      bus.alloc_arch_num = 5'd7;
      total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", bus.alloc_ready); end
      total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL full_commit_valid got=%b want=1", bus.commit_valid); end
      total++; if (bus.commit_data !== 32'h55) begin bad++; $display("FAIL full_commit_data got=%h want=55", bus.commit_data); end
      tick();
      void'(sbq.pop_front());
      bus.alloc_req = 1'b0;
      bus.commit_ready = 1'b0;
      total++; if (bus.count !== 5'd15) begin bad++; $display("FAIL full_count got=%0d want=15", bus.count); end
      total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b want=1", bus.alloc_ready); end
      total++; if (bus.alloc_tag !== mdl_tail) begin bad++; $display("FAIL full_next_tag got=%0d want=%0d", bus.alloc_tag, mdl_tail); end
      alloc(5'd9);
      tick();
      bus.alloc_req = 1'b0;
      total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL full_refill_count got=%0d want=16", bus.count); end
   endtask

   task automatic test_bypass;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc(5'(i + 10));
         tick();
      end
      bus.alloc_req = 1'b0;
      bus.rd_tag = 4'd3;
      #1;
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL byp_before got=%b want=0", bus.rd_valid); end
      cdb(1, 4'd3, 32'h1234);
      #1;
      total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL byp_cdb_valid got=%b want=1", bus.rd_valid); end
      total++; if (bus.rd_data !== 32'h1234) begin bad++; $display("FAIL byp_cdb_data got=%h want=1234", bus.rd_data); end
      tick();
      bus.cdb_valid = '0;
      #1;
      total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL byp_store_valid got=%b want=1", bus.rd_valid); end
      total++; if (bus.rd_data !== 32'h1234) begin bad++; $display("FAIL byp_store_data got=%h want=1234", bus.rd_data); end
      bus.rd_tag = 4'd2;
      cdb(0, 4'd2, 32'h77);
      #1;
      total++; if (bus.rd_data !== 32'h77) begin bad++; $display("FAIL byp_port0_data got=%h want=77", bus.rd_data); end
      bus.cdb_valid = '0;
   endtask

   task automatic test_flush;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         alloc(5'(i + 1));
         tick();
      end
      bus.alloc_req = 1'b0;
      cdb(0, 4'd0, 32'h11);
      tick();
      bus.cdb_valid = '0;
      total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%b want=1", bus.commit_valid); end
      bus.flush = 1'b1;
      bus.commit_ready = 1'b1;
      cdb(0, 4'd1, 32'h22);
      #1;
      total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL flush_commit_forced got=%b want=0", bus.commit_valid); end
      total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_alloc_ready got=%b want=1", bus.alloc_ready); end
      tick();
      idle_inputs();
      sbq.delete();
      mdl_tail = '0;
      #1;
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", bus.count); end
      total++; if (bus.alloc_tag !== mdl_tail) begin bad++; $display("FAIL flush_tag got=%0d want=%0d", bus.alloc_tag, mdl_tail); end
      bus.rd_tag = 4'd1;
      #1;
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL flush_no_write got=%b want=0", bus.rd_valid); end
      alloc(5'd6); tick();
      alloc(5'd7); tick();
      bus.alloc_req = 1'b0;
      cdb(0, 4'd9, 32'h99);
      tick();
      bus.cdb_valid = '0;
      bus.rd_tag = 4'd9;
      #1;
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL flush_unocc_write got=%b want=0", bus.rd_valid); end
      total++; if (bus.count !== 5'd2) begin bad++; $display("FAIL flush_realloc_count got=%0d want=2", bus.count); end
      total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL flush_realloc_commit got=%b want=0", bus.commit_valid); end
      #2;
      rstn = 1'b0;
      #1;
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL async_rst_count got=%0d want=0", bus.count); end
      total++; if (bus.alloc_tag !== 4'd0) begin bad++; $display("FAIL async_rst_tag got=%0d want=0", bus.alloc_tag); end
      rstn = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rstn  = 1'b1;
      mdl_tail = '0;
      for (int i = 0; i < 16; i++) mdl_data[i] = '0;
      idle_inputs();
      test_reset();
      test_fill();
      test_out_of_order();
      test_full_commit_alloc();
      test_bypass();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
